// File: rtl/cpu_lockstep_checker_pkg.sv
// Shared types and helpers for the reference/DUV lockstep comparator.
package cpu_lockstep_checker_pkg;

   // Checker run state, encoded as seen on state_o.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // Architectural channel positions inside a commit record.
   localparam int CH_A  = 0;
   localparam int CH_X  = 1;
   localparam int CH_Y  = 2;
   localparam int CH_P  = 3;
   localparam int CH_SP = 4;
   localparam int CH_PC = 5;

   // Upper bounds for the generic channel extractor below.
   localparam int MAX_DATA_W = 64;
   localparam int MAX_REC_W  = 1024;

   // Extract channel k of a (zero-extended) record whose channels are data_w bits wide.
   function automatic logic [MAX_DATA_W-1:0] ch_slice(input logic [MAX_REC_W-1:0] rec,
                                                      input int unsigned k,
                                                      input int unsigned data_w);
      logic [MAX_REC_W-1:0]  shifted;
      logic [MAX_DATA_W-1:0] lane_msk;
      shifted  = rec >> (k * data_w);
      lane_msk = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - data_w);
      return shifted[MAX_DATA_W-1:0] & lane_msk;
   endfunction

endpackage

// File: rtl/cpu_lockstep_checker_if.sv
// Bundle of control, commit streams and results of the lockstep checker.
interface cpu_lockstep_checker_if #(
   parameter int NUM_CH = 6,
   parameter int DATA_W = 16,
   parameter int CNT_W  = 32
);
   logic                     enable_i;
   logic                     stop_on_err_i;
   logic [NUM_CH-1:0]        ch_mask_i;
   logic                     ref_valid_i;
   logic [NUM_CH*DATA_W-1:0] ref_rec_i;
   logic                     duv_valid_i;
   logic [NUM_CH*DATA_W-1:0] duv_rec_i;
   logic [1:0]               state_o;
   logic [CNT_W-1:0]         cmp_count_o;
   logic [CNT_W-1:0]         err_count_o;
   logic                     err_flag_o;
   logic [NUM_CH-1:0]        err_ch_o;
   logic [CNT_W-1:0]         err_idx_o;
   logic [NUM_CH*DATA_W-1:0] err_ref_o;
   logic [NUM_CH*DATA_W-1:0] err_duv_o;
   logic                     overflow_o;
   logic                     timeout_o;

   modport master (
      output enable_i, stop_on_err_i, ch_mask_i,
      output ref_valid_i, ref_rec_i, duv_valid_i, duv_rec_i,
      input  state_o, cmp_count_o, err_count_o, err_flag_o, err_ch_o,
      input  err_idx_o, err_ref_o, err_duv_o, overflow_o, timeout_o
   );

   modport slave (
      input  enable_i, stop_on_err_i, ch_mask_i,
      input  ref_valid_i, ref_rec_i, duv_valid_i, duv_rec_i,
      output state_o, cmp_count_o, err_count_o, err_flag_o, err_ch_o,
      output err_idx_o, err_ref_o, err_duv_o, overflow_o, timeout_o
   );
endinterface

// File: rtl/cpu_lockstep_checker_fifo.sv
// Skew FIFO holding commit records of one core until the other core catches up.
module cpu_lockstep_checker_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 96
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;

   // Extra pointer MSB distinguishes full from empty when the indices coincide.
   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign head  = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer update; flush discards all entries. Caller only pushes when space or a pop exists.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         if (pop)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
   end

   // Storage write; a push into a full FIFO with a pop overwrites the slot just read.
   always_ff @(posedge clk) begin
      if (push) mem_r[wr_ptr_r[AW-1:0]] <= din;
   end

endmodule

// File: rtl/cpu_lockstep_checker.sv
// Lockstep comparator: pairs reference and DUV commit records, compares them under
// a channel mask, counts pairs/mismatches, captures the first mismatch and flags
// overflow or runaway skew.
module cpu_lockstep_checker
   import cpu_lockstep_checker_pkg::*;
#(
   parameter int NUM_CH   = 6,
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 8,
   parameter int MAX_SKEW = 64,
   parameter int CNT_W    = 32
) (
   input logic                   clk,
   input logic                   rst,
   cpu_lockstep_checker_if.slave bus
);
   localparam int REC_W  = NUM_CH * DATA_W;
   localparam int SKEW_W = $clog2(MAX_SKEW + 1);

   state_t             state_r;
   state_t             state_nxt_s;
   logic [REC_W-1:0]   ref_head_s, duv_head_s;
   logic [MAX_REC_W-1:0] ref_ext_s, duv_ext_s;
   logic               ref_full_s, ref_empty_s, duv_full_s, duv_empty_s;
   logic               run_s, pop_s, ref_push_s, duv_push_s, flush_s, enter_s;
   logic               one_side_s, ovf_s, tmo_s, mis_s, halt_s;
   logic [NUM_CH-1:0]  diff_s;
   logic [SKEW_W-1:0]  skew_r;
   logic [CNT_W-1:0]   cmp_count_r, err_count_r, err_idx_r;
   logic               err_flag_r, overflow_r, timeout_r;
   logic [NUM_CH-1:0]  err_ch_r;
   logic [REC_W-1:0]   err_ref_r, err_duv_r;

   cpu_lockstep_checker_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_ref_fifo (
      .clk(clk), .rst(rst), .flush(flush_s), .push(ref_push_s), .pop(pop_s),
      .din(bus.ref_rec_i), .full(ref_full_s), .empty(ref_empty_s), .head(ref_head_s)
   );

   cpu_lockstep_checker_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_duv_fifo (
      .clk(clk), .rst(rst), .flush(flush_s), .push(duv_push_s), .pop(pop_s),
      .din(bus.duv_rec_i), .full(duv_full_s), .empty(duv_empty_s), .head(duv_head_s)
   );

   assign ref_ext_s = MAX_REC_W'(ref_head_s);
   assign duv_ext_s = MAX_REC_W'(duv_head_s);

   // Per-channel masked difference of the two FIFO heads.
   always_comb begin
      diff_s = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         diff_s[k] = bus.ch_mask_i[k] &
                     (ch_slice(ref_ext_s, k, DATA_W) != ch_slice(duv_ext_s, k, DATA_W));
      end
   end

   // Datapath control and HALT causes; nothing moves unless running and enabled.
   always_comb begin
      run_s      = (state_r == ST_RUN) && bus.enable_i;
      enter_s    = (state_r == ST_IDLE) && bus.enable_i;
      flush_s    = !bus.enable_i || (state_r == ST_IDLE);
      pop_s      = run_s && !ref_empty_s && !duv_empty_s;
      ref_push_s = run_s && bus.ref_valid_i && (!ref_full_s || pop_s);
      duv_push_s = run_s && bus.duv_valid_i && (!duv_full_s || pop_s);
      ovf_s      = run_s && ((bus.ref_valid_i && ref_full_s && !pop_s) ||
                             (bus.duv_valid_i && duv_full_s && !pop_s));
      one_side_s = ref_empty_s ^ duv_empty_s;
      tmo_s      = run_s && one_side_s && (skew_r == SKEW_W'(MAX_SKEW - 1));
      mis_s      = pop_s && (diff_s != '0);
      halt_s     = ovf_s || tmo_s || (mis_s && bus.stop_on_err_i);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nxt_s;
   end

   // FSM next state; dropping enable always returns to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      if (!bus.enable_i) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: state_nxt_s = ST_RUN;
            ST_RUN:  state_nxt_s = halt_s ? ST_HALT : ST_RUN;
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Skew counter: cycles in which only one side holds entries.
   always_ff @(posedge clk) begin
      if (rst || !run_s || !one_side_s) skew_r <= '0;
      else                              skew_r <= skew_r + {{(SKEW_W-1){1'b0}}, 1'b1};
   end

   // Registered compare results, sticky flags and first-mismatch capture.
   always_ff @(posedge clk) begin
      if (rst || enter_s) begin
         cmp_count_r <= '0;
         err_count_r <= '0;
         err_idx_r   <= '0;
         err_flag_r  <= 1'b0;
         err_ch_r    <= '0;
         err_ref_r   <= '0;
         err_duv_r   <= '0;
         overflow_r  <= 1'b0;
         timeout_r   <= 1'b0;
      end else if (run_s) begin
         if (pop_s && (cmp_count_r != {CNT_W{1'b1}}))
            cmp_count_r <= cmp_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         if (mis_s) begin
            err_flag_r <= 1'b1;
            if (err_count_r != {CNT_W{1'b1}})
               err_count_r <= err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (!err_flag_r) begin
               err_ch_r  <= diff_s;
               err_idx_r <= cmp_count_r;
               err_ref_r <= ref_head_s;
               err_duv_r <= duv_head_s;
            end
         end
         if (ovf_s) overflow_r <= 1'b1;
         if (tmo_s) timeout_r  <= 1'b1;
      end
   end

   assign bus.state_o     = state_r;
   assign bus.cmp_count_o = cmp_count_r;
   assign bus.err_count_o = err_count_r;
   assign bus.err_flag_o  = err_flag_r;
   assign bus.err_ch_o    = err_ch_r;
   assign bus.err_idx_o   = err_idx_r;
   assign bus.err_ref_o   = err_ref_r;
   assign bus.err_duv_o   = err_duv_r;
   assign bus.overflow_o  = overflow_r;
   assign bus.timeout_o   = timeout_r;

endmodule
